// File: rtl/sgpr_wr_port_arbiter.sv
// Per-port 1-entry holding registers with round-robin selection
// feeding the SGPR write-port mux one write per cycle.
module sgpr_wr_port_arbiter #(
    parameter int NUM_PORTS = 8,
    parameter int SEL_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_stall,
    input  logic [NUM_PORTS-1:0]    req_valid,
    output logic [NUM_PORTS-1:0]    req_ready,
    input  logic [9*NUM_PORTS-1:0]  req_addr,
    input  logic [64*NUM_PORTS-1:0] req_data,
    input  logic [64*NUM_PORTS-1:0] req_mask,
    output logic [NUM_PORTS-1:0]    held_wr_en,
    output logic [9*NUM_PORTS-1:0]  held_wr_addr,
    output logic [64*NUM_PORTS-1:0] held_wr_data,
    output logic [64*NUM_PORTS-1:0] held_wr_mask,
    output logic [SEL_W-1:0]        wr_port_select,
    output logic                    grant_fire
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]    valid_q;
    logic [NUM_PORTS-1:0]    gnt;
    logic [NUM_PORTS-1:0]    accept;
    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        gnt_idx;
    logic [PTR_W-1:0]        idx;
    logic [9*NUM_PORTS-1:0]  addr_q;
    logic [64*NUM_PORTS-1:0] data_q;
    logic [64*NUM_PORTS-1:0] mask_q;

    // Scan from the farthest offset down so the nearest valid port wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        if (!wr_stall) begin
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                idx = rr_ptr + PTR_W'(k);
                if (valid_q[idx]) begin
                    gnt      = '0;
                    gnt[idx] = 1'b1;
                    gnt_idx  = idx;
                end
            end
        end
    end

    assign req_ready      = ~valid_q | gnt;
    assign accept         = req_valid & req_ready;
    assign grant_fire     = |gnt;
    assign wr_port_select = {{(SEL_W-NUM_PORTS){1'b0}}, gnt};
    assign held_wr_en     = valid_q;
    assign held_wr_addr   = addr_q;
    assign held_wr_data   = data_q;
    assign held_wr_mask   = mask_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            rr_ptr  <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (accept[i]) begin
                    valid_q[i]      <= 1'b1;
                    addr_q[9*i +: 9]   <= req_addr[9*i +: 9];
                    data_q[64*i +: 64] <= req_data[64*i +: 64];
                    mask_q[64*i +: 64] <= req_mask[64*i +: 64];
                end else if (gnt[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
            if (grant_fire) begin
                rr_ptr <= gnt_idx + PTR_W'(1);
            end
        end
    end

endmodule
